rtr_output_vc_sched: RTL and testbench



---
 rtl/rtr_output_vc_sched.sv | 184 ++++++++++++++++++
 tb/tb_rtr_output_vc_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtr_output_vc_sched.sv
// rtr_output_vc_sched
// Per-output-port flit scheduler feeding the router's channel output stage.
// Each cycle at most one VC is picked round-robin from the VCs that have a
// flit ready and at least one downstream credit. Downstream credits are
// tracked per VC, and a link power-management "active" signal gates the
// output-stage registers when the port has been quiet long enough.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   vc_req            VC v has a flit ready at its head
//   vc_head, vc_tail  head/tail flags of each VC's front flit
//   vc_gnt            one-hot pop strobe back to the VCs (combinational)
//   flit_valid_out    a flit is sent this cycle
//   flit_head_out     head flag of the granted VC (0 without a grant)
//   flit_tail_out     tail flag of the granted VC (0 without a grant)
//   flit_sel_out_ovc  one-hot VC select into the output stage (same as vc_gnt)
//   credit_valid_in   a credit is returned from downstream this cycle
//   credit_vc_in      VC index of the returned credit
//   active            registered link / clock-gate enable
//   credit_err        sticky credit-overflow or bad-VC-index error

module rtr_output_vc_sched #(
   parameter int num_vcs      = 4,
   parameter int buffer_size  = 8,
   parameter int idle_timeout = 4,
   parameter int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1,
   parameter int cred_width   = $clog2(buffer_size + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [num_vcs-1:0]      vc_req,
   input  logic [num_vcs-1:0]      vc_head,
   input  logic [num_vcs-1:0]      vc_tail,
   output logic [num_vcs-1:0]      vc_gnt,
   output logic                    flit_valid_out,
   output logic                    flit_head_out,
   output logic                    flit_tail_out,
   output logic [num_vcs-1:0]      flit_sel_out_ovc,
   input  logic                    credit_valid_in,
   input  logic [vc_idx_width-1:0] credit_vc_in,
   output logic                    active,
   output logic                    credit_err
);

   localparam int idle_width = $clog2(idle_timeout + 1);
   localparam logic [cred_width-1:0] cred_full = cred_width'(buffer_size);
   localparam logic [idle_width-1:0] idle_last = idle_width'(idle_timeout - 1);

   logic [cred_width-1:0]   cred [num_vcs];
   logic [vc_idx_width-1:0] ptr;
   logic [vc_idx_width-1:0] ptr_next;
   logic [idle_width-1:0]   idle_cnt;

   logic [num_vcs-1:0] eligible;
   logic [num_vcs-1:0] credit_hit;
   logic [num_vcs-1:0] overflow;
   logic               bad_vc;
   logic               outstanding;
   logic               act_ev;
   logic               found;
   int                 cand;
   int                 nxt;

   // A VC may be granted only when it has a flit, holds at least one
   // downstream credit, and the link is awake. Tying eligibility to active
   // is what keeps every combinational output at zero while the port sleeps.
   always_comb begin
      eligible = '0;
      for (int v = 0; v < num_vcs; v++) begin
         eligible[v] = vc_req[v] & (cred[v] != '0) & active;
      end
   end

   // Round-robin search starting at the pointer and wrapping around; the
   // first eligible VC wins. The pointer moves to one past the winner so the
   // winner becomes lowest priority next time.
   always_comb begin
      vc_gnt   = '0;
      found    = 1'b0;
      cand     = 0;
      nxt      = 0;
      ptr_next = ptr;
      for (int i = 0; i < num_vcs; i++) begin
         cand = int'(ptr) + i;
         if (cand >= num_vcs) begin
            cand = cand - num_vcs;
         end
         if (!found && eligible[cand]) begin
            found        = 1'b1;
            vc_gnt[cand] = 1'b1;
            nxt          = cand + 1;
            if (nxt >= num_vcs) begin
               nxt = 0;
            end
            ptr_next = vc_idx_width'(nxt);
         end
      end
   end

   // Decode the returned credit, flag out-of-range indices, and spot credits
   // arriving at an already-full counter. A credit that coincides with a
   // grant on the same VC nets out and is never an overflow.
   always_comb begin
      credit_hit  = '0;
      overflow    = '0;
      outstanding = 1'b0;
      for (int v = 0; v < num_vcs; v++) begin
         if (credit_valid_in && (credit_vc_in == vc_idx_width'(v))) begin
            credit_hit[v] = 1'b1;
         end
         overflow[v] = credit_hit[v] & ~vc_gnt[v] & (cred[v] == cred_full);
         if (cred[v] != cred_full) begin
            outstanding = 1'b1;
         end
      end
      bad_vc = credit_valid_in & ~(|credit_hit);
      act_ev = (|vc_req) | credit_valid_in | outstanding;
   end

   // The output stage sees the granted VC's flags, masked to zero when no VC
   // is granted.
   always_comb begin
      flit_valid_out   = |vc_gnt;
      flit_head_out    = |(vc_gnt & vc_head);
      flit_tail_out    = |(vc_gnt & vc_tail);
      flit_sel_out_ovc = vc_gnt;
   end

   // Per-VC credit counters. Grants consume a credit, returns restore one,
   // both together leave the count alone. Counters saturate at the buffer
   // depth, and any overflow or bad index latches credit_err until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < num_vcs; v++) begin
            cred[v] <= cred_full;
         end
         credit_err <= 1'b0;
      end else begin
         for (int v = 0; v < num_vcs; v++) begin
            if (credit_hit[v] && !vc_gnt[v]) begin
               if (cred[v] != cred_full) begin
                  cred[v] <= cred[v] + cred_width'(1);
               end
            end else if (vc_gnt[v] && !credit_hit[v]) begin
               cred[v] <= cred[v] - cred_width'(1);
            end
         end
         if (bad_vc || (|overflow)) begin
            credit_err <= 1'b1;
         end
      end
   end

   // Round-robin pointer advances only on a grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= ptr_next;
      end
   end

   // Link power management. Any request, credit return, or outstanding
   // credit keeps the link awake, so credits still in flight are never lost
   // to gating. After idle_timeout quiet edges the link goes to sleep; a new
   // request wakes it on the next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         active   <= 1'b0;
         idle_cnt <= '0;
      end else if (act_ev) begin
         active   <= 1'b1;
         idle_cnt <= '0;
      end else if (active) begin
         if (idle_cnt == idle_last) begin
            active   <= 1'b0;
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + idle_width'(1);
         end
      end
   end

endmodule

// File: tb/tb_rtr_output_vc_sched.sv
// tb_rtr_output_vc_sched
// Self-checking bench for rtr_output_vc_sched with 4 VCs, 8-deep downstream
// buffers and an idle timeout of 4. Expected grants are queued as stimulus
// is applied and popped as the scheduler issues grants.

module tb_rtr_output_vc_sched;

   logic       clk;
   logic       reset;
   logic [3:0] vc_req;
   logic [3:0] vc_head;
   logic [3:0] vc_tail;
   logic [3:0] vc_gnt;
   logic       flit_valid_out;
   logic       flit_head_out;
   logic       flit_tail_out;
   logic [3:0] flit_sel_out_ovc;
   logic       credit_valid_in;
   logic [1:0] credit_vc_in;
   logic       active;
   logic       credit_err;

   int checks;
   int passes;
   int exp_q[$];

   rtr_output_vc_sched #(
      .num_vcs      (4),
      .buffer_size  (8),
      .idle_timeout (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .vc_req           (vc_req),
      .vc_head          (vc_head),
      .vc_tail          (vc_tail),
      .vc_gnt           (vc_gnt),
      .flit_valid_out   (flit_valid_out),
      .flit_head_out    (flit_head_out),
      .flit_tail_out    (flit_tail_out),
      .flit_sel_out_ovc (flit_sel_out_ovc),
      .credit_valid_in  (credit_valid_in),
      .credit_vc_in     (credit_vc_in),
      .active           (active),
      .credit_err       (credit_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Returns the index of a one-hot grant, -1 for no grant, -2 for several.
   function automatic int onehot_idx(input logic [3:0] g);
      int idx;
      int n;
      idx = -1;
      n = 0;
      for (int v = 0; v < 4; v++) begin
         if (g[v]) begin
            idx = v;
            n++;
         end
      end
      if (n > 1) idx = -2;
      return idx;
   endfunction

   // Move to just after the next rising edge, where new inputs are driven.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Two reset edges with quiet inputs; returns at the start of cycle t0.
   task automatic do_reset();
      reset           = 1'b1;
      vc_req          = '0;
      vc_head         = '0;
      vc_tail         = '0;
      credit_valid_in = 1'b0;
      credit_vc_in    = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Reset values, gated outputs while asleep, and one-cycle wake latency.
   task automatic test_reset();
      do_reset();
      vc_req = 4'b1111;
      @(negedge clk);
      checks++;
      if (active !== 1'b0 || credit_err !== 1'b0)
         $display("[TB] FAIL reset_regs: active=%b credit_err=%b, want 0/0", active, credit_err);
      else passes++;
      checks++;
      if (vc_gnt !== 4'b0000 || flit_valid_out !== 1'b0 || flit_head_out !== 1'b0 || flit_tail_out !== 1'b0)
         $display("[TB] FAIL reset_outputs: gnt=%b valid=%b head=%b tail=%b, want all 0",
                  vc_gnt, flit_valid_out, flit_head_out, flit_tail_out);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if (active !== 1'b1 || vc_gnt !== 4'b0001)
         $display("[TB] FAIL wake_grant: active=%b gnt=%b, want 1/0001", active, vc_gnt);
      else passes++;
   endtask

   // All four VCs requesting: strict rotation until every credit is spent.
   task automatic test_round_robin();
      int g;
      int e;
      do_reset();
      vc_req = 4'b1111;
      for (int k = 0; k < 32; k++) exp_q.push_back(k % 4);
      @(negedge clk);
      checks++;
      if (active !== 1'b0 || vc_gnt !== 4'b0000)
         $display("[TB] FAIL rr_t0: active=%b gnt=%b, want 0/0000", active, vc_gnt);
      else passes++;
      next_cycle();
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         g = onehot_idx(vc_gnt);
         if (g != -1) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL rr_extra: cycle %0d gnt=%b, want no grant", c, vc_gnt);
            end else begin
               e = exp_q.pop_front();
               if (g !== e || flit_sel_out_ovc !== vc_gnt || flit_valid_out !== 1'b1)
                  $display("[TB] FAIL rr_order: cycle %0d got vc %0d sel=%b valid=%b, want vc %0d",
                           c, g, flit_sel_out_ovc, flit_valid_out, e);
               else passes++;
            end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0)
         $display("[TB] FAIL rr_missing: %0d grants not seen, want 0", exp_q.size());
      else passes++;
      @(negedge clk);
      checks++;
      if (active !== 1'b1 || vc_gnt !== 4'b0000)
         $display("[TB] FAIL rr_drained: active=%b gnt=%b, want 1/0000", active, vc_gnt);
      else passes++;
   endtask

   // Reset during traffic puts the pointer back to VC0.
   task automatic test_mid_reset();
      do_reset();
      vc_req = 4'b1111;
      repeat (4) next_cycle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (active !== 1'b0 || vc_gnt !== 4'b0000)
         $display("[TB] FAIL midrst_state: active=%b gnt=%b, want 0/0000", active, vc_gnt);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if (vc_gnt !== 4'b0001)
         $display("[TB] FAIL midrst_ptr: gnt=%b, want 0001", vc_gnt);
      else passes++;
   endtask

   // Single VC drains its credits, stalls, and resumes for one returned credit.
   task automatic test_starvation();
      int g;
      int e;
      do_reset();
      vc_req = 4'b0100;
      for (int k = 0; k < 8; k++) exp_q.push_back(2);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         g = onehot_idx(vc_gnt);
         if (g != -1) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL starve_extra: cycle %0d gnt=%b, want no grant", c, vc_gnt);
            end else begin
               e = exp_q.pop_front();
               if (g !== e) $display("[TB] FAIL starve_vc: got vc %0d, want vc %0d", g, e);
               else passes++;
            end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0)
         $display("[TB] FAIL starve_missing: %0d grants not seen, want 0", exp_q.size());
      else passes++;
      credit_valid_in = 1'b1;
      credit_vc_in    = 2'd2;
      @(negedge clk);
      checks++;
      if (vc_gnt !== 4'b0000)
         $display("[TB] FAIL starve_return_cycle: gnt=%b, want 0000", vc_gnt);
      else passes++;
      next_cycle();
      credit_valid_in = 1'b0;
      @(negedge clk);
      checks++;
      if (vc_gnt !== 4'b0100)
         $display("[TB] FAIL starve_resume: gnt=%b, want 0100", vc_gnt);
      else passes++;
      next_cycle();
      @(negedge clk);
      checks++;
      if (vc_gnt !== 4'b0000)
         $display("[TB] FAIL starve_once: gnt=%b, want 0000", vc_gnt);
      else passes++;
   endtask

   // Grant and credit return on VC1 at count 3 cancel out: 5+1+3 grants total.
   task automatic test_simultaneous();
      int g;
      int e;
      do_reset();
      vc_req       = 4'b0010;
      credit_vc_in = 2'd1;
      for (int k = 0; k < 9; k++) exp_q.push_back(1);
      for (int c = 0; c < 15; c++) begin
         credit_valid_in = (c == 6);
         @(negedge clk);
         g = onehot_idx(vc_gnt);
         if (g != -1) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL simul_extra: cycle %0d gnt=%b, want no grant", c, vc_gnt);
            end else begin
               e = exp_q.pop_front();
               if (g !== e) $display("[TB] FAIL simul_vc: got vc %0d, want vc %0d", g, e);
               else passes++;
            end
         end
         next_cycle();
      end
      credit_valid_in = 1'b0;
      checks++;
      if (exp_q.size() != 0)
         $display("[TB] FAIL simul_missing: %0d grants not seen, want 0", exp_q.size());
      else passes++;
      @(negedge clk);
      checks++;
      if (credit_err !== 1'b0)
         $display("[TB] FAIL simul_err: credit_err=%b, want 0", credit_err);
      else passes++;
   endtask

   // Credit to a full VC0: saturates, latches credit_err until reset.
   task automatic test_overflow();
      int g;
      int e;
      do_reset();
      credit_valid_in = 1'b1;
      credit_vc_in    = 2'd0;
      @(negedge clk);
      checks++;
      if (credit_err !== 1'b0)
         $display("[TB] FAIL ovf_before: credit_err=%b, want 0", credit_err);
      else passes++;
      next_cycle();
      credit_valid_in = 1'b0;
      @(negedge clk);
      checks++;
      if (credit_err !== 1'b1)
         $display("[TB] FAIL ovf_set: credit_err=%b, want 1", credit_err);
      else passes++;
      repeat (100) next_cycle();
      @(negedge clk);
      checks++;
      if (credit_err !== 1'b1 || active !== 1'b0)
         $display("[TB] FAIL ovf_sticky: credit_err=%b active=%b, want 1/0", credit_err, active);
      else passes++;
      next_cycle();
      vc_req = 4'b0001;
      for (int k = 0; k < 8; k++) exp_q.push_back(0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         g = onehot_idx(vc_gnt);
         if (g != -1) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL ovf_extra: cycle %0d gnt=%b, want no grant", c, vc_gnt);
            end else begin
               e = exp_q.pop_front();
               if (g !== e) $display("[TB] FAIL ovf_vc: got vc %0d, want vc %0d", g, e);
               else passes++;
            end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0)
         $display("[TB] FAIL ovf_missing: %0d grants not seen, want 0", exp_q.size());
      else passes++;
      do_reset();
      @(negedge clk);
      checks++;
      if (credit_err !== 1'b0)
         $display("[TB] FAIL ovf_clear: credit_err=%b, want 0", credit_err);
      else passes++;
   endtask

   // Sleep after 4 quiet edges and wake on a new request.
   task automatic test_idle_timeout();
      logic       exp_act;
      logic [3:0] exp_gnt;
      do_reset();
      for (int c = 0; c <= 22; c++) begin
         if (c == 10) vc_req = 4'b0001;
         else if (c == 20 || c == 21) vc_req = 4'b0100;
         else vc_req = 4'b0000;
         exp_act = ((c >= 11) && (c <= 14)) || (c >= 21);
         exp_gnt = (c == 21) ? 4'b0100 : 4'b0000;
         @(negedge clk);
         checks++;
         if (active !== exp_act)
            $display("[TB] FAIL idle_active: cycle %0d active=%b, want %b", c, active, exp_act);
         else passes++;
         checks++;
         if (vc_gnt !== exp_gnt)
            $display("[TB] FAIL idle_gnt: cycle %0d gnt=%b, want %b", c, vc_gnt, exp_gnt);
         else passes++;
         next_cycle();
      end
      vc_req = 4'b0000;
   endtask

   // Head/tail flags follow the granted VC only.
   task automatic test_head_tail();
      logic [3:0] req_t [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
      logic [3:0] hd_t  [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b1111, 4'b0111};
      logic [3:0] tl_t  [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1111, 4'b0111};
      logic       exp_h [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         vc_req  = req_t[c];
         vc_head = hd_t[c];
         vc_tail = tl_t[c];
         @(negedge clk);
         checks++;
         if (flit_head_out !== exp_h[c] || flit_tail_out !== exp_t[c])
            $display("[TB] FAIL head_tail: step %0d head=%b tail=%b, want %b/%b",
                     c, flit_head_out, flit_tail_out, exp_h[c], exp_t[c]);
         else passes++;
         next_cycle();
      end
   endtask

   // Run every scenario in turn and print the tally.
   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_round_robin();
      test_mid_reset();
      test_starvation();
      test_simultaneous();
      test_overflow();
      test_idle_timeout();
      test_head_tail();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
